r_type_issue: RTL and testbench
===============================

Name: r_type_issue

Overview:
- Multi-cycle issue/writeback sequencer for R-type instructions.
- Accepts 32-bit instructions over a valid/ready handshake and owns a 32x32 integer register file.
- For each instruction it reads the rs1/rs2 operands, drives the external R-type ALU (instr/in1/in2 -> out), captures the ALU result and writes it to rd.
- It is the producer of ALU operands and the consumer of ALU results in the single-cycle-to-multicycle datapath.

Parameters:
- XLEN, 32, data width of registers and ALU operands.
- NREGS, 32, register count; register index width is 5.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept.
- instr  in  32  instruction word.
- alu_instr  out  32  latched instruction to ALU.
- alu_in1  out  XLEN  rs1 operand to ALU.
- alu_in2  out  XLEN  rs2 operand to ALU.
- alu_out  in  XLEN  combinational ALU result.
- done  out  1  one-cycle pulse: instruction retired.
- illegal  out  1  one-cycle pulse: instruction rejected.
- wb_en  out  1  one-cycle pulse, register write occurring.
- wb_rd  out  5  write destination.
- wb_data  out  XLEN  write data.
- dbg_we  in  1  debug register write (preload).
- dbg_addr  in  5  debug read/write index.
- dbg_wdata  in  XLEN  debug write data.
- dbg_rdata  out  XLEN  combinational read of reg[dbg_addr].

Behaviour:
- Reset:
  - state=IDLE; all registers, latched instr and operand regs = 0.
  - All outputs = 0, including instr_ready while rst is asserted.
  - Reset mid-operation aborts the instruction; no writeback, no done.
- FSM states: IDLE, READ, EXEC, WB, ILL.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr.
  - Legal when opcode[6:0]=7'b0110011 and funct7 is 7'h00 (any funct3), or funct7 is 7'h20 with funct3 000 or 101.
  - Legal -> READ; otherwise -> ILL.
- ILL: illegal=1 for one cycle, no state change to registers -> IDLE.
- READ: operand regs <= reg[rs1], reg[rs2]; x0 reads 0. -> EXEC.
- EXEC:
  - alu_instr, alu_in1 and alu_in2 are registered and stable all of EXEC and WB.
  - result reg <= alu_out at end of EXEC. -> WB.
- WB:
  - done=1.
  - If rd!=0: wb_en=1, wb_rd=rd, wb_data=result, reg[rd]<=result at end of cycle.
  - If rd=0: wb_en=0, x0 stays 0. -> IDLE.
- instr_ready=0 in READ, EXEC, WB and ILL.
- Timing (accept at cycle T):
  - illegal asserted in T+1.
  - done asserted in T+3.
  - Next accept no earlier than T+4 (legal) or T+2 (illegal).
- No hazards: the next READ always follows the prior WB commit.
- Debug port:
  - dbg_we honoured only in IDLE when no instruction is accepted the same cycle; ignored otherwise.
  - Writes to index 0 are ignored.
  - dbg_rdata reflects the array contents before any same-cycle write (WB or debug).
- alu_out is sampled only in EXEC; its value in other states is don't-care.
- Signedness lives in the ALU. The sequencer moves XLEN-bit words untouched, with no extension or truncation.

Test Plan:
- Add: preload x1=5, x2=7 via debug; issue 0x002081B3 (add x3,x1,x2) -> instr_ready low for 3 cycles; done and wb_en pulse at T+3 with wb_rd=3, wb_data=12; dbg_rdata(3)=12.
- Sub to negative: x1=5, x2=7; issue 0x40208233 (sub x4,x1,x2) -> wb_data=32'hFFFFFFFE, reg x4 updated.
- Arithmetic shift: x1=32'h80000000, x2=4; issue 0x4020D2B3 (sra x5,x1,x2) -> wb_data=32'hF8000000.
- x0 write: issue 0x00208033 (add x0,x1,x2) -> done pulses, wb_en stays 0, dbg_rdata(0)=0.
- Illegal rejection: issue 0x00108093 (I-type) and 0x40209133 (funct7=0x20 with sll) -> illegal pulses at T+1, no done, all registers unchanged, instr_ready back high at T+2.
- Reset abort and backpressure:
  - Hold instr_valid high with back-to-back adds; accepts must be exactly 4 cycles apart.
  - Assert rst during EXEC -> all outputs 0 immediately, rd unwritten, all registers read 0 after release.

Source files
------------

// File: rtl/r_type_issue.sv
// Issue/writeback sequencer for R-type instructions: accepts an instruction, reads
// rs1/rs2 from its own register file, drives the external ALU and commits the result.
module r_type_issue #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [31:0]     alu_instr,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic [XLEN-1:0] alu_out,
    output logic            done,
    output logic            illegal,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic            dbg_we,
    input  logic [4:0]      dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic [XLEN-1:0] dbg_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        ILL  = 3'd4
    } state_t;

    state_t          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] regs [NREGS];

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       accept;
    logic       legal;
    logic       commit;
    logic       dbg_write;

    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign rd  = ir[11:7];

    // Handshake: a transfer happens on a rising edge where instr_valid && instr_ready;
    // instr_ready depends only on state (and reset), never on instr_valid.
    assign instr_ready = (state == IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        legal = 1'b0;
        if (instr[6:0] == 7'b0110011) begin
            if (instr[31:25] == 7'h00)
                legal = 1'b1;
            else if (instr[31:25] == 7'h20 &&
                     (instr[14:12] == 3'b000 || instr[14:12] == 3'b101))
                legal = 1'b1;
        end
    end

    assign commit    = (state == WB) && (rd != 5'd0);
    assign dbg_write = dbg_we && (state == IDLE) && !accept && (dbg_addr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ir     <= '0;
            op1    <= '0;
            op2    <= '0;
            result <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ir    <= instr;
                        state <= legal ? READ : ILL;
                    end else if (dbg_write) begin
                        regs[dbg_addr] <= dbg_wdata;
                    end
                end
                READ: begin
                    op1   <= (rs1 == 5'd0) ? '0 : regs[rs1];
                    op2   <= (rs2 == 5'd0) ? '0 : regs[rs2];
                    state <= EXEC;
                end
                EXEC: begin
                    result <= alu_out;
                    state  <= WB;
                end
                WB: begin
                    if (rd != 5'd0)
                        regs[rd] <= result;
                    state <= IDLE;
                end
                ILL:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ALU operands come straight from registers, so they hold through EXEC and WB.
    assign alu_instr = ir;
    assign alu_in1   = op1;
    assign alu_in2   = op2;

    assign done      = (state == WB);
    assign illegal   = (state == ILL);
    assign wb_en     = commit;
    assign wb_rd     = commit ? rd : 5'd0;
    assign wb_data   = commit ? result : '0;
    assign dbg_rdata = regs[dbg_addr];

endmodule

// File: tb/tb_r_type_issue.sv
// Bench for r_type_issue: behavioural R-type ALU, register-file reference model and
// a writeback scoreboard fed at issue time and drained on wb_en.
module tb_r_type_issue;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            instr_valid = 1'b0;
    logic            instr_ready;
    logic [31:0]     instr = '0;
    logic [31:0]     alu_instr;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [XLEN-1:0] alu_out;
    logic            done;
    logic            illegal;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            dbg_we = 1'b0;
    logic [4:0]      dbg_addr = '0;
    logic [XLEN-1:0] dbg_wdata = '0;
    logic [XLEN-1:0] dbg_rdata;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;
    logic [31:0] ref_regs [32];

    always #5 clk = ~clk;

    r_type_issue #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_instr(alu_instr), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
        .done(done), .illegal(illegal),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (ins[14:12])
            3'b000:  return ins[30] ? a - b : a + b;
            3'b001:  return a << sh;
            3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  return (a < b) ? 32'd1 : 32'd0;
            3'b100:  return a ^ b;
            3'b101:  return ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb alu_out = alu_ref(alu_instr, alu_in1, alu_in2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb_en) begin
            check("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e[36:32]});
                check("wb_data", wb_data, mon_e[31:0]);
            end
        end
    end

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        @(posedge clk); #1;
        dbg_we = 1'b0;
        if (a != 5'd0) ref_regs[a] = d;
    endtask

    task automatic dbg_check(input string tag, input logic [4:0] a, input logic [31:0] e);
        @(negedge clk);
        dbg_addr = a;
        #1;
        check(tag, dbg_rdata, e);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) dbg_check(tag, 5'(i), ref_regs[i]);
    endtask

    task automatic issue(input logic [31:0] ins);
        logic legal;
        logic [4:0] rd;
        logic [31:0] res;
        legal = (ins[6:0] == 7'b0110011) && ((ins[31:25] == 7'h00) ||
                (ins[31:25] == 7'h20 && (ins[14:12] == 3'b000 || ins[14:12] == 3'b101)));
        rd = ins[11:7];
        @(negedge clk);
        check("ready_idle", instr_ready, 1);
        instr_valid = 1'b1; instr = ins;
        if (legal) begin
            res = alu_ref(ins, ref_regs[ins[19:15]], ref_regs[ins[24:20]]);
            if (rd != 5'd0) begin
                exp_q.push_back({rd, res});
                ref_regs[rd] = res;
            end
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("ready_t1", instr_ready, 0);
        check("illegal_t1", illegal, !legal);
        if (!legal) begin
            @(posedge clk); #1;
            check("ready_t2_ill", instr_ready, 1);
            check("illegal_t2", illegal, 0);
            check("done_ill", done, 0);
        end else begin
            @(posedge clk); #1;
            check("ready_t2", instr_ready, 0);
            check("done_t2", done, 0);
            check("alu_instr", alu_instr, ins);
            @(posedge clk); #1;
            check("done_t3", done, 1);
            check("wb_en_t3", wb_en, rd != 5'd0);
            check("ready_t3", instr_ready, 0);
            @(posedge clk); #1;
            check("ready_t4", instr_ready, 1);
            check("done_t4", done, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;
        int last_cyc;
        logic [31:0] res;
        logic [2:0] f3;
        logic [6:0] f7;
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;

        #2;
        check("rst_ready", instr_ready, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_alu_instr", alu_instr, 0);
        check("rst_alu_in1", alu_in1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd7);
        issue(32'h002081B3);
        dbg_check("add_x3", 5'd3, 32'd12);
        issue(32'h40208233);
        dbg_check("sub_x4", 5'd4, 32'hFFFFFFFE);
        dbg_write(5'd1, 32'h80000000);
        dbg_write(5'd2, 32'd4);
        issue(32'h4020D2B3);
        dbg_check("sra_x5", 5'd5, 32'hF8000000);
        issue(32'h00208033);
        dbg_check("x0_add", 5'd0, 32'd0);
        issue(32'h00108093);
        issue(32'h40209133);
        check_all("ill_regs");

        for (int r = 1; r < 8; r++) dbg_write(5'(r), $urandom);
        for (int k = 0; k < 12; k++) begin
            f3 = 3'($urandom_range(0, 7));
            f7 = ((f3 == 3'b000 || f3 == 3'b101) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            issue({f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3,
                   5'($urandom_range(0, 7)), 7'b0110011});
        end
        check_all("rand_regs");

        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hDEADBEEF;
        instr_valid = 1'b1; instr = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dbg_we = 1'b0; instr_valid = 1'b0;
        check("ill_ffff", illegal, 1);
        dbg_check("dbg_ignored", 5'd9, ref_regs[9]);
        dbg_write(5'd0, 32'h1234);
        dbg_check("x0_dbg", 5'd0, 32'd0);

        accepts = 0;
        last_cyc = 0;
        instr = 32'h00130333;
        @(negedge clk);
        instr_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && accepts < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (instr_ready) begin
                if (accepts > 0) check("b2b_gap", cyc - last_cyc, 4);
                last_cyc = cyc;
                accepts++;
                res = ref_regs[6] + ref_regs[1];
                ref_regs[6] = res;
                exp_q.push_back({5'd6, res});
                if (accepts == 4) begin
                    @(posedge clk); #1;
                    instr_valid = 1'b0;
                end
            end
        end
        instr_valid = 1'b0;
        check("b2b_accepts", accepts, 4);
        repeat (4) @(posedge clk);
        dbg_check("b2b_x6", 5'd6, ref_regs[6]);

        @(negedge clk);
        instr = 32'h002083B3; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("exec_in1", alu_in1, ref_regs[1]);
        check("exec_in2", alu_in2, ref_regs[2]);
        rst = 1'b1;
        #1;
        check("abort_ready", instr_ready, 0);
        check("abort_done", done, 0);
        check("abort_wb_en", wb_en, 0);
        check("abort_alu_instr", alu_instr, 0);
        check("abort_alu_in1", alu_in1, 0);
        check("abort_alu_in2", alu_in2, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        repeat (3) @(posedge clk);
        check_all("post_rst");
        check("post_rst_ready", instr_ready, 1);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
